tff_count_ctrl: RTL and testbench

- Sequencer for a bank of WIDTH toggle flip-flops wired as a synchronous up-counter.
- Generates the per-bit toggle mask each cycle and holds the bank state internally as `count`.
- Runs from 0 to a latched target, then signals completion through a done/ack handshake.
- Supports hold (pause) and abort; used wherever the team needs a programmable T-FF-based interval counter.

---
 rtl/tff_count_ctrl_if.sv | 25 ++
 rtl/tff_count_ctrl.sv | 111 +++++++++++
 tb/tb_tff_count_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// Handshake bundle between the interval-counter sequencer and its user.
// The master drives the controls; the slave returns mask, count and status.
interface tff_count_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] target;
   logic             hold;
   logic             abort;
   logic             ack;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output start, target, hold, abort, ack,
      input  t_vec, count, busy, done
   );

   modport slave (
      input  start, target, hold, abort, ack,
      output t_vec, count, busy, done
   );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer for a T flip-flop bank used as a programmable up-counter.
// Define TFF_AUTO_RELOAD_EN to restart automatically after each done.
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   tff_count_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] target_l;
   logic [WIDTH-1:0] target_n;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] t_vec;
   logic             active;
   logic             busy;
   logic             done;

   // Ripple-AND carry: bit i toggles when all lower bits are one.
   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         carry[i] = carry[i-1] & count[i-1];
      end
      active = (state == RUN) && !bus.hold && !bus.abort
               && (count != target_l);
      t_vec  = active ? carry : '0;
   end

   always_comb begin
      state_n  = state;
      count_n  = count ^ t_vec;
      target_n = target_l;
      unique case (state)
         IDLE: begin
            count_n = '0;
            if (bus.start) begin
               state_n  = RUN;
               target_n = bus.target;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_n = IDLE;
               count_n = '0;
            end else if (count == target_l) begin
               state_n = DONE;
            end else if (bus.hold) begin
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (bus.abort) begin
               state_n = IDLE;
               count_n = '0;
            end else if (!bus.hold) begin
               state_n = RUN;
            end
         end
         DONE: begin
`ifdef TFF_AUTO_RELOAD_EN
            count_n = '0;
            state_n = bus.abort ? IDLE : RUN;
`else
            if (bus.ack || bus.abort) begin
               state_n = IDLE;
               count_n = '0;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            count_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         target_l <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         target_l <= target_n;
         busy     <= (state_n == RUN) || (state_n == HOLD);
         done     <= (state_n == DONE);
      end
   end

   assign bus.t_vec = t_vec;
   assign bus.count = count;
   assign bus.busy  = busy;
   assign bus.done  = done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed vector bench for tff_count_ctrl with WIDTH=4.
// Outputs are sampled 1ns after each rising edge.
module tb_tff_count_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   tff_count_ctrl_if #(.WIDTH(4)) bus ();

   tff_count_ctrl #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       start;
      logic [3:0] target;
      logic       hold;
      logic       abort;
      logic       ack;
      logic [3:0] e_cnt;
      logic [3:0] e_tv;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];

   task automatic add(
      input logic r, s, input logic [3:0] tg,
      input logic h, a, k,
      input logic [3:0] ec, et, input logic eb, ed
   );
      vec_t v;
      v.rst = r; v.start = s; v.target = tg;
      v.hold = h; v.abort = a; v.ack = k;
      v.e_cnt = ec; v.e_tv = et;
      v.e_busy = eb; v.e_done = ed;
      tbl.push_back(v);
   endtask

   task automatic chk(
      input string nm, input logic [3:0] act, input logic [3:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(
      input logic r, s, input logic [3:0] tg, input logic h, a, k
   );
      rst        = r;
      bus.start  = s;
      bus.target = tg;
      bus.hold   = h;
      bus.abort  = a;
      bus.ack    = k;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(
      input string nm, input logic [3:0] ec, et, input logic eb, ed
   );
      chk({nm, " count"}, bus.count, ec);
      chk({nm, " t_vec"}, bus.t_vec, et);
      chk({nm, " busy"}, {3'b0, bus.busy}, {3'b0, eb});
      chk({nm, " done"}, {3'b0, bus.done}, {3'b0, ed});
   endtask

   initial begin
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
`ifdef TFF_AUTO_RELOAD_EN
      tick();
      drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("ar e0", 4'd0, 4'd1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk($sformatf("ar e%0d done", e), {3'b0, bus.done},
             {3'b0, (e % 4) == 3});
         chk($sformatf("ar e%0d busy", e), {3'b0, bus.busy},
             {3'b0, (e % 4) != 3});
         chk($sformatf("ar e%0d count", e), bus.count,
             (e % 4 == 0) ? 4'd0 : ((e % 4) == 1 ? 4'd1 : 4'd2));
      end
      drive(1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("ar abort", 4'd0, 4'd0, 1'b0, 1'b0);
`else
      // rst start tgt hold abort ack | count t_vec busy done
      add(1,1,5, 0,0,0, 0,0,0,0);
      add(1,1,5, 0,0,0, 0,0,0,0);
      add(0,0,5, 0,0,0, 0,0,0,0);
      add(0,0,5, 1,0,1, 0,0,0,0);
      add(0,1,5, 0,0,0, 0,4'h1,1,0);
      add(0,0,5, 0,0,0, 1,4'h3,1,0);
      add(0,0,5, 0,0,0, 2,4'h1,1,0);
      add(0,0,5, 0,0,0, 3,4'h7,1,0);
      add(0,0,5, 0,0,0, 4,4'h1,1,0);
      add(0,0,5, 0,0,0, 5,4'h0,1,0);
      add(0,0,5, 0,0,0, 5,4'h0,0,1);
      add(0,1,5, 0,0,0, 5,4'h0,0,1);
      add(0,1,5, 0,0,1, 0,4'h0,0,0);
      add(0,0,5, 0,0,0, 0,4'h0,0,0);
      add(0,1,3, 0,0,0, 0,4'h1,1,0);
      add(0,0,9, 0,0,0, 1,4'h3,1,0);
      add(0,0,0, 0,0,0, 2,4'h1,1,0);
      add(0,0,15,0,0,0, 3,4'h0,1,0);
      add(0,0,15,0,0,0, 3,4'h0,0,1);
      add(0,0,15,0,0,1, 0,4'h0,0,0);
      add(0,1,4, 0,0,0, 0,4'h1,1,0);
      add(0,0,4, 0,0,0, 1,4'h3,1,0);
      add(0,0,4, 0,0,0, 2,4'h1,1,0);
      add(0,0,4, 1,0,0, 2,4'h0,1,0);
      add(0,0,4, 1,0,0, 2,4'h0,1,0);
      add(0,0,4, 1,0,0, 2,4'h0,1,0);
      add(0,0,4, 0,0,0, 2,4'h1,1,0);
      add(0,0,4, 0,0,0, 3,4'h7,1,0);
      add(0,0,4, 0,0,0, 4,4'h0,1,0);
      add(0,0,4, 0,0,0, 4,4'h0,0,1);
      add(0,0,4, 0,0,1, 0,4'h0,0,0);
      add(0,1,9, 0,0,0, 0,4'h1,1,0);
      add(0,0,9, 0,0,0, 1,4'h3,1,0);
      add(0,0,9, 0,0,0, 2,4'h1,1,0);
      add(0,0,9, 0,0,0, 3,4'h7,1,0);
      add(0,0,9, 1,1,1, 0,4'h0,0,0);
      add(0,0,9, 0,0,0, 0,4'h0,0,0);
      add(0,1,9, 0,0,0, 0,4'h1,1,0);
      add(0,0,9, 0,0,0, 1,4'h3,1,0);
      add(0,0,9, 0,0,0, 2,4'h1,1,0);
      add(0,0,9, 0,0,0, 3,4'h7,1,0);
      add(1,1,9, 1,0,1, 0,4'h0,0,0);
      add(0,0,9, 0,0,0, 0,4'h0,0,0);
      add(0,1,0, 0,0,0, 0,4'h0,1,0);
      add(0,0,0, 0,0,0, 0,4'h0,0,1);
      add(0,0,0, 0,1,0, 0,4'h0,0,0);
      add(0,1,6, 0,0,0, 0,4'h1,1,0);
      add(0,0,6, 1,0,0, 0,4'h0,1,0);
      add(0,0,6, 1,1,0, 0,4'h0,0,0);
      add(0,0,6, 0,0,0, 0,4'h0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].start, tbl[i].target,
               tbl[i].hold, tbl[i].abort, tbl[i].ack);
         tick();
         chk_all($sformatf("v%0d", i), tbl[i].e_cnt, tbl[i].e_tv,
                 tbl[i].e_busy, tbl[i].e_done);
      end

      // Full-range run: no wrap past 15.
      drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("f15 e0", 4'd0, 4'd1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("f15 e%0d count", k), bus.count, 4'(k));
         if (k == 7) chk("f15 tv7", bus.t_vec, 4'hf);
      end
      chk("f15 tv15", bus.t_vec, 4'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("f15 done%0d", k), 4'd15, 4'd0, 1'b0, 1'b1);
      end
      drive(1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1);
      tick();
      chk_all("f15 ack", 4'd0, 4'd0, 1'b0, 1'b0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
